// File: rtl/stage_sample_mixer_if.sv
// stage_sample_mixer_if -- operator stream in, mixed sample out.
//
// Groups the operator input fields and the sample output handshake of
// stage_sample_mixer.
//   master : operator producer / sample consumer (drives i_*, reads o_*)
//   slave  : the mixer (reads i_*, drives o_*)
// ID_W must equal clog2(NUM_VOICES*NUM_OPERATORS) of the attached mixer.
interface stage_sample_mixer_if #(
  parameter int ID_W = 8
);
  logic                i_OperatorValid;
  logic [ID_W-1:0]     i_VoiceOperator;
  logic                i_IsCarrier;
  logic [2:0]          i_NumCarriersM1;
  logic signed [15:0]  i_OperatorOutput;
  logic                o_SampleValid;
  logic                i_SampleReady;
  logic signed [15:0]  o_Sample;
  logic                o_SampleDropped;
  logic                o_Clipped;

  modport master (
    output i_OperatorValid, i_VoiceOperator, i_IsCarrier, i_NumCarriersM1,
           i_OperatorOutput, i_SampleReady,
    input  o_SampleValid, o_Sample, o_SampleDropped, o_Clipped
  );

  modport slave (
    input  i_OperatorValid, i_VoiceOperator, i_IsCarrier, i_NumCarriersM1,
           i_OperatorOutput, i_SampleReady,
    output o_SampleValid, o_Sample, o_SampleDropped, o_Clipped
  );
endinterface

// File: rtl/stage_sample_mixer.sv
// stage_sample_mixer -- scales each carrier operator output by a
// carrier-count compensation factor, sums one frame of operators and
// presents the mixed sample on a valid/ready output register.
//
// Ports:
//   i_Clock : sole clock, all state on rising edge
//   i_Reset : synchronous active-high reset
//   bus     : stage_sample_mixer_if.slave
//             i_OperatorValid/i_VoiceOperator/i_IsCarrier/i_NumCarriersM1/
//             i_OperatorOutput in; o_SampleValid/i_SampleReady/o_Sample/
//             o_SampleDropped/o_Clipped out
//
// Optional feature macro: SAMPLE_SATURATION_EN
//   defined   : out-of-range shifted sums clamp to 16-bit bounds, o_Clipped pulses
//   undefined : o_Sample is the low 16 bits of the shifted sum, o_Clipped = 0
//
// Latency: a frame-end id sampled on edge N shows o_SampleValid after edge
// N+16 (16 multiply stages, then the output register).
module stage_sample_mixer #(
  parameter int NUM_VOICES    = 32,
  parameter int NUM_OPERATORS = 8,
  parameter int OUTPUT_SHIFT  = $clog2(NUM_VOICES)
) (
  input logic                 i_Clock,
  input logic                 i_Reset,
  stage_sample_mixer_if.slave bus
);

  localparam int STAGES = 16;
  localparam int ID_W   = $clog2(NUM_VOICES * NUM_OPERATORS);
  localparam int ACC_W  = 16 + $clog2(NUM_VOICES);
  localparam logic [ID_W-1:0] ID_FRAME_END = '1;

  function automatic logic [15:0] comp_factor(input logic [2:0] m1);
    case (m1)
      3'd0:    comp_factor = 16'h7fff;
      3'd1:    comp_factor = 16'h4000;
      3'd2:    comp_factor = 16'h2aaa;
      3'd3:    comp_factor = 16'h2000;
      3'd4:    comp_factor = 16'h1999;
      3'd5:    comp_factor = 16'h1555;
      3'd6:    comp_factor = 16'h1249;
      default: comp_factor = 16'h1000;
    endcase
  endfunction

  logic [15:0] in_factor;
  assign in_factor = comp_factor(bus.i_NumCarriersM1);

  // Shift-add multiplier: stage s adds (operand << s) when factor bit s is set.
  // The remaining factor bits shift down so the next stage always looks at
  // bit 0; the last stage needs neither operand nor factor.
  logic [STAGES-1:0]  vld_q;
  logic signed [32:0] pp_q  [STAGES];
  logic [ID_W-1:0]    id_q  [STAGES];
  logic               car_q [STAGES];
  logic signed [15:0] op_q  [STAGES-1];
  logic [14:0]        fac_q [STAGES-1];

  // NOTE: sequential state uses non-blocking (<=) so every stage samples the
  // previous stage's value from before the edge, not the freshly written one.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) vld_q <= '0;
    else         vld_q <= {vld_q[STAGES-2:0], bus.i_OperatorValid};
  end

  // NOTE: data registers carry no reset; nothing downstream acts on them
  // unless the matching vld_q bit is set, and that bit is reset.
  always_ff @(posedge i_Clock) begin
    pp_q[0]  <= in_factor[0] ? 33'(bus.i_OperatorOutput) : 33'sd0;
    op_q[0]  <= bus.i_OperatorOutput;
    fac_q[0] <= in_factor[15:1];
    id_q[0]  <= bus.i_VoiceOperator;
    car_q[0] <= bus.i_IsCarrier;
    for (int s = 1; s < STAGES; s++) begin
      pp_q[s]  <= pp_q[s-1] + (fac_q[s-1][0] ? (33'(op_q[s-1]) <<< s) : 33'sd0);
      id_q[s]  <= id_q[s-1];
      car_q[s] <= car_q[s-1];
    end
    for (int s = 1; s < STAGES - 1; s++) begin
      op_q[s]  <= op_q[s-1];
      fac_q[s] <= fac_q[s-1] >> 1;
    end
  end

  // Accumulate stage.
  logic                    acc_vld;
  logic signed [15:0]      comp;
  logic signed [ACC_W-1:0] contrib;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    frame_start;
  logic                    frame_end;
  logic                    sync_q;
  logic                    load;

  assign acc_vld     = vld_q[STAGES-1];
  assign comp        = pp_q[STAGES-1][30:15];   // >>15, floor toward -inf
  assign frame_start = acc_vld && (id_q[STAGES-1] == '0);
  assign frame_end   = acc_vld && (id_q[STAGES-1] == ID_FRAME_END);
  assign load        = frame_end && sync_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    contrib = '0;
    if (car_q[STAGES-1]) contrib = ACC_W'(comp);
    acc_sum = (frame_start ? '0 : acc_q) + contrib;
  end

  logic signed [15:0] sample_next;
`ifdef SAMPLE_SATURATION_EN
  logic signed [ACC_W-1:0] shifted;
  logic                    overflow;
  logic                    clip_q;

  always_comb begin
    shifted     = acc_sum >>> OUTPUT_SHIFT;
    // In range only if every bit above bit 15 repeats the sign bit.
    overflow    = shifted[ACC_W-1:15] != {(ACC_W-15){shifted[ACC_W-1]}};
    sample_next = shifted[15:0];
    if (overflow) sample_next = shifted[ACC_W-1] ? 16'sh8000 : 16'sh7fff;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) clip_q <= 1'b0;
    else         clip_q <= load && overflow;
  end
  assign bus.o_Clipped = clip_q;
`else
  always_comb begin
    sample_next = 16'(acc_sum >>> OUTPUT_SHIFT);
  end
  assign bus.o_Clipped = 1'b0;
`endif

  logic               smp_vld_q;
  logic signed [15:0] smp_q;
  logic               drop_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      acc_q     <= '0;
      sync_q    <= 1'b0;
      smp_vld_q <= 1'b0;
      smp_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      if (acc_vld)     acc_q  <= acc_sum;
      if (frame_start) sync_q <= 1'b1;
      // A load into an unconsumed, not-being-accepted sample overwrites it.
      drop_q <= load && smp_vld_q && !bus.i_SampleReady;
      if (load) begin
        smp_q     <= sample_next;
        smp_vld_q <= 1'b1;
      end else if (bus.i_SampleReady) begin
        smp_vld_q <= 1'b0;
      end
    end
  end

  assign bus.o_SampleValid   = smp_vld_q;
  assign bus.o_Sample        = smp_q;
  assign bus.o_SampleDropped = drop_q;

endmodule

// File: tb/tb_stage_sample_mixer.sv
// Directed bench for stage_sample_mixer: two instances (NUM_VOICES=2,
// NUM_OPERATORS=2) with OUTPUT_SHIFT=1 (dut1) and OUTPUT_SHIFT=0 (dut0)
// receive identical stimulus.
module tb_stage_sample_mixer;

`ifdef SAMPLE_SATURATION_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stage_sample_mixer_if #(.ID_W(2)) bus1 ();
  stage_sample_mixer_if #(.ID_W(2)) bus0 ();

  stage_sample_mixer #(.NUM_VOICES(2), .NUM_OPERATORS(2), .OUTPUT_SHIFT(1)) u_dut1 (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus1)
  );

  stage_sample_mixer #(.NUM_VOICES(2), .NUM_OPERATORS(2), .OUTPUT_SHIFT(0)) u_dut0 (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus0)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic drive(input logic v, input logic [1:0] id, input logic car,
                       input logic [2:0] m1, input logic [15:0] op);
    bus1.i_OperatorValid  = v;   bus0.i_OperatorValid  = v;
    bus1.i_VoiceOperator  = id;  bus0.i_VoiceOperator  = id;
    bus1.i_IsCarrier      = car; bus0.i_IsCarrier      = car;
    bus1.i_NumCarriersM1  = m1;  bus0.i_NumCarriersM1  = m1;
    bus1.i_OperatorOutput = op;  bus0.i_OperatorOutput = op;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0, 3'd0, 16'h0000);
  endtask

  task automatic set_ready(input logic r);
    bus1.i_SampleReady = r;
    bus0.i_SampleReady = r;
  endtask

  task automatic frame(input logic [3:0] car, input logic [2:0] m1,
                       input logic [15:0] o0, input logic [15:0] o1,
                       input logic [15:0] o2, input logic [15:0] o3);
    drive(1'b1, 2'd0, car[0], m1, o0);
    drive(1'b1, 2'd1, car[1], m1, o1);
    drive(1'b1, 2'd2, car[2], m1, o2);
    drive(1'b1, 2'd3, car[3], m1, o3);
  endtask

  // Called right after a frame's id 3 was sampled: checks exact latency,
  // values, pulses, holding while not ready, then consumes the sample.
  task automatic finish_frame(input string tag, input logic [15:0] exp1,
                              input logic [15:0] exp0, input logic clip0);
    idle(15);
    check({tag, "_early_valid"}, 16'(bus1.o_SampleValid), 16'h0);
    idle(1);
    check({tag, "_valid1"},  16'(bus1.o_SampleValid),   16'h1);
    check({tag, "_sample1"}, bus1.o_Sample,             exp1);
    check({tag, "_valid0"},  16'(bus0.o_SampleValid),   16'h1);
    check({tag, "_sample0"}, bus0.o_Sample,             exp0);
    check({tag, "_clip1"},   16'(bus1.o_Clipped),       16'h0);
    check({tag, "_clip0"},   16'(bus0.o_Clipped),       16'(clip0));
    check({tag, "_drop1"},   16'(bus1.o_SampleDropped), 16'h0);
    idle(3);
    check({tag, "_hold_valid"},  16'(bus1.o_SampleValid), 16'h1);
    check({tag, "_hold_sample"}, bus1.o_Sample,           exp1);
    check({tag, "_clip_pulse"},  16'(bus0.o_Clipped),     16'h0);
    set_ready(1'b1);
    idle(1);
    set_ready(1'b0);
    check({tag, "_consumed"}, 16'(bus1.o_SampleValid), 16'h0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt1;
    int cnt0;

    rst = 1'b1;
    set_ready(1'b0);
    idle(3);
    check("rst_valid",   16'(bus1.o_SampleValid),   16'h0);
    check("rst_sample",  bus1.o_Sample,             16'h0000);
    check("rst_dropped", 16'(bus1.o_SampleDropped), 16'h0);
    check("rst_clipped", 16'(bus0.o_Clipped),       16'h0);
    rst = 1'b0;
    idle(2);

    // Carriers 0,2 at 4000, factor 7fff: each 0x1fffc000>>15 = 3fff, sum 7ffe.
    frame(4'b0101, 3'd0, 16'h4000, 16'h0000, 16'h4000, 16'h0000);
    finish_frame("basic", 16'h3fff, 16'h7ffe, 1'b0);

    // Four carriers 7ffe, factor 4000: each 3fff, sum fffc (17-bit positive).
    frame(4'b1111, 3'd1, 16'h7ffe, 16'h7ffe, 16'h7ffe, 16'h7ffe);
    finish_frame("four_car", 16'h7ffe, SAT ? 16'h7fff : 16'hfffc, SAT);

    // Two carriers 7fff, factor 7fff: each 7ffe, sum fffc.
    frame(4'b0101, 3'd0, 16'h7fff, 16'h1111, 16'h7fff, 16'h2222);
    finish_frame("clip", 16'h7ffe, SAT ? 16'h7fff : 16'hfffc, SAT);

    // -1 * 7fff >>15 floors to -1; two carriers give -2; non-carriers ignored.
    frame(4'b0101, 3'd0, 16'hffff, 16'h7fff, 16'hffff, 16'h1234);
    finish_frame("negative", 16'hffff, 16'hfffe, 1'b0);

    // Back-to-back frames, not ready: second (factor 1999 * 4000 -> ccc)
    // overwrites the first.
    frame(4'b0101, 3'd0, 16'h4000, 16'h0000, 16'h4000, 16'h0000);
    frame(4'b0001, 3'd4, 16'h4000, 16'h0000, 16'h0000, 16'h0000);
    cnt1 = 0;
    cnt0 = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      cnt1 += int'(bus1.o_SampleDropped);
      cnt0 += int'(bus0.o_SampleDropped);
    end
    check("drop_count1", 16'(cnt1), 16'd1);
    check("drop_count0", 16'(cnt0), 16'd1);
    check("drop_valid",  16'(bus1.o_SampleValid), 16'h1);
    check("drop_sample1", bus1.o_Sample, 16'h0666);
    check("drop_sample0", bus0.o_Sample, 16'h0ccc);
    set_ready(1'b1);
    idle(1);
    set_ready(1'b0);

    // Reset for one cycle while id 2 is presented.
    drive(1'b1, 2'd0, 1'b1, 3'd0, 16'h4000);
    drive(1'b1, 2'd1, 1'b0, 3'd0, 16'h0000);
    rst = 1'b1;
    drive(1'b1, 2'd2, 1'b1, 3'd0, 16'h4000);
    rst = 1'b0;
    check("midrst_valid",  16'(bus1.o_SampleValid), 16'h0);
    check("midrst_sample", bus1.o_Sample,           16'h0000);
    drive(1'b1, 2'd3, 1'b0, 3'd0, 16'h0000);
    cnt1 = 0;
    for (int i = 0; i < 25; i++) begin
      idle(1);
      cnt1 += int'(bus1.o_SampleValid);
    end
    check("midrst_no_sample", 16'(cnt1), 16'd0);
    frame(4'b0101, 3'd0, 16'h4000, 16'h0000, 16'h4000, 16'h0000);
    finish_frame("after_rst", 16'h3fff, 16'h7ffe, 1'b0);

    // Fresh reset, stray id 3 without id 0, then one full frame.
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    set_ready(1'b1);
    drive(1'b1, 2'd3, 1'b1, 3'd0, 16'h4000);
    frame(4'b0101, 3'd0, 16'h4000, 16'h0000, 16'h4000, 16'h0000);
    cnt1 = 0;
    cnt0 = 0;
    for (int i = 0; i < 30; i++) begin
      idle(1);
      cnt1 += int'(bus1.o_SampleValid);
      cnt0 += int'(bus0.o_SampleValid);
    end
    check("sync_count1",  16'(cnt1), 16'd1);
    check("sync_count0",  16'(cnt0), 16'd1);
    check("sync_sample1", bus1.o_Sample, 16'h3fff);
    set_ready(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
